// File: rtl/rat_ret_stack.sv
// Return-address stack feeding the PC mux; FROM_STACK is registered and valid one cycle after a push/pop.
// No backpressure: a push while full is dropped and flagged, a pop while empty is ignored and flagged.
module rat_ret_stack #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 8
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         PUSH,
  input  logic                         POP,
  input  logic [ADDR_W-1:0]            PUSH_DATA,
  input  logic                         CLR_ERR,
  output logic [ADDR_W-1:0]            FROM_STACK,
  output logic [$clog2(DEPTH+1)-1:0]   COUNT,
  output logic                         FULL,
  output logic                         EMPTY,
  output logic                         OVERFLOW,
  output logic                         UNDERFLOW
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] entries [DEPTH];

  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_nxt;
  logic [ADDR_W-1:0] top_q;
  logic [ADDR_W-1:0] top_nxt;
  logic              ovf_q;
  logic              unf_q;
  logic              ovf_set;
  logic              unf_set;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic              is_full;
  logic              is_empty;

  assign is_full  = (count_q == CNT_FULL);
  assign is_empty = (count_q == CNT_ZERO);

  assign FROM_STACK = top_q;
  assign COUNT      = count_q;
  assign FULL       = is_full;
  assign EMPTY      = is_empty;
  assign OVERFLOW   = ovf_q;
  assign UNDERFLOW  = unf_q;

  always_comb begin
    count_nxt = count_q;
    top_nxt   = top_q;
    wr_en     = 1'b0;
    wr_idx    = '0;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;

    case ({PUSH, POP})
      2'b10: begin
        if (is_full) begin
          ovf_set = 1'b1;
        end else begin
          wr_en     = 1'b1;
          wr_idx    = IDX_W'(count_q);
          count_nxt = count_q + CNT_ONE;
          top_nxt   = PUSH_DATA;
        end
      end
      2'b01: begin
        if (is_empty) begin
          unf_set = 1'b1;
        end else if (count_q == CNT_ONE) begin
          count_nxt = CNT_ZERO;
          top_nxt   = '0;
        end else begin
          count_nxt = count_q - CNT_ONE;
          top_nxt   = entries[IDX_W'(count_q - CNT_TWO)];
        end
      end
      2'b11: begin
        // Push+pop is a top replace; on an empty stack it degrades to a plain push.
        wr_en   = 1'b1;
        top_nxt = PUSH_DATA;
        if (is_empty) begin
          unf_set   = 1'b1;
          wr_idx    = '0;
          count_nxt = CNT_ONE;
        end else begin
          wr_idx = IDX_W'(count_q - CNT_ONE);
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count_q <= '0;
      top_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_nxt;
      top_q   <= top_nxt;
      // A new error event in the clearing cycle keeps the flag set.
      ovf_q   <= ovf_set | (ovf_q & ~CLR_ERR);
      unf_q   <= unf_set | (unf_q & ~CLR_ERR);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST_N && wr_en) begin
      entries[wr_idx] <= PUSH_DATA;
    end
  end

endmodule

// File: tb/tb_rat_ret_stack.sv
// Bench for rat_ret_stack: two depths driven in lockstep against an array-based stack model.
module tb_rat_ret_stack;

  localparam int AW = 10;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b1;
  logic          PUSH = 1'b0;
  logic          POP = 1'b0;
  logic          CLR_ERR = 1'b0;
  logic [AW-1:0] PUSH_DATA = '0;

  logic [AW-1:0] top4, top8;
  logic [2:0]    cnt4;
  logic [3:0]    cnt8;
  logic          full4, empty4, ovf4, unf4;
  logic          full8, empty8, ovf8, unf8;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Model state: index 0 mirrors the depth-4 instance, index 1 the depth-8 one.
  logic [AW-1:0] mem [2][8];
  int            mcnt [2];
  bit            movf [2];
  bit            munf [2];

  logic [AW-1:0] pc = '0;
  logic          pc_ld = 1'b0;

  always #5 CLK = ~CLK;

  rat_ret_stack #(.ADDR_W(AW), .DEPTH(4)) dut4 (
    .CLK(CLK), .RST_N(RST_N), .PUSH(PUSH), .POP(POP), .PUSH_DATA(PUSH_DATA),
    .CLR_ERR(CLR_ERR), .FROM_STACK(top4), .COUNT(cnt4), .FULL(full4),
    .EMPTY(empty4), .OVERFLOW(ovf4), .UNDERFLOW(unf4)
  );

  rat_ret_stack #(.ADDR_W(AW), .DEPTH(8)) dut8 (
    .CLK(CLK), .RST_N(RST_N), .PUSH(PUSH), .POP(POP), .PUSH_DATA(PUSH_DATA),
    .CLR_ERR(CLR_ERR), .FROM_STACK(top8), .COUNT(cnt8), .FULL(full8),
    .EMPTY(empty8), .OVERFLOW(ovf8), .UNDERFLOW(unf8)
  );

  // Stand-in for the PC register with its mux fixed on the stack input.
  always @(posedge CLK) begin
    if (pc_ld) pc <= top8;
    else       pc <= pc + 10'd1;
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int depth_of(input int k);
    return (k == 0) ? 4 : 8;
  endfunction

  function automatic int exp_top(input int k);
    return (mcnt[k] == 0) ? 0 : int'(mem[k][mcnt[k]-1]);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mcnt[k] = 0;
      movf[k] = 1'b0;
      munf[k] = 1'b0;
    end
  endtask

  task automatic model_step(input bit psh, input bit pp, input logic [AW-1:0] d, input bit clr);
    for (int k = 0; k < 2; k++) begin
      if (clr) begin
        movf[k] = 1'b0;
        munf[k] = 1'b0;
      end
      if (psh && !pp) begin
        if (mcnt[k] == depth_of(k)) movf[k] = 1'b1;
        else begin
          mem[k][mcnt[k]] = d;
          mcnt[k]++;
        end
      end else if (pp && !psh) begin
        if (mcnt[k] == 0) munf[k] = 1'b1;
        else mcnt[k]--;
      end else if (pp && psh) begin
        if (mcnt[k] == 0) begin
          munf[k] = 1'b1;
          mem[k][0] = d;
          mcnt[k] = 1;
        end else begin
          mem[k][mcnt[k]-1] = d;
        end
      end
    end
  endtask

  // Single compare process: every falling edge, both instances against the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("d4.from_stack", top4, exp_top(0));
      chk("d4.count", cnt4, mcnt[0]);
      chk("d4.full", full4, mcnt[0] == 4);
      chk("d4.empty", empty4, mcnt[0] == 0);
      chk("d4.overflow", ovf4, movf[0]);
      chk("d4.underflow", unf4, munf[0]);
      chk("d8.from_stack", top8, exp_top(1));
      chk("d8.count", cnt8, mcnt[1]);
      chk("d8.full", full8, mcnt[1] == 8);
      chk("d8.empty", empty8, mcnt[1] == 0);
      chk("d8.overflow", ovf8, movf[1]);
      chk("d8.underflow", unf8, munf[1]);
    end
  end

  // Called at a falling edge; drives one cycle of inputs and returns at the next falling edge.
  task automatic cycle(input bit psh, input bit pp, input logic [AW-1:0] d, input bit clr);
    PUSH = psh;
    POP = pp;
    PUSH_DATA = d;
    CLR_ERR = clr;
    @(posedge CLK);
    model_step(psh, pp, d, clr);
    @(negedge CLK);
  endtask

  initial begin
    model_reset();
    #2 RST_N = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;

    // Reset / idle
    cycle(0, 0, 10'h000, 0);
    chk("idle.from_stack", top8, 0);
    chk("idle.count", cnt8, 0);
    chk("idle.empty", empty8, 1);
    chk("idle.full", full8, 0);
    chk("idle.flags", {ovf8, unf8}, 0);

    // Push / pop sequence
    cycle(1, 0, 10'h003, 0); chk("push1.top", top8, 'h003); chk("push1.count", cnt8, 1);
    cycle(1, 0, 10'h010, 0); chk("push2.top", top8, 'h010); chk("push2.count", cnt8, 2);
    cycle(1, 0, 10'h3FE, 0); chk("push3.top", top8, 'h3FE); chk("push3.count", cnt8, 3);
    cycle(0, 1, 10'h000, 0); chk("pop1.top", top8, 'h010);
    cycle(0, 1, 10'h000, 0); chk("pop2.top", top8, 'h003);
    cycle(0, 1, 10'h000, 0); chk("pop3.top", top8, 'h000); chk("pop3.empty", empty8, 1);

    // Overflow on the depth-4 instance
    for (int i = 1; i <= 4; i++) cycle(1, 0, AW'(i), 0);
    chk("ovf.full_before", full4, 1);
    cycle(1, 0, 10'h005, 0);
    chk("ovf.flag", ovf4, 1);
    chk("ovf.count", cnt4, 4);
    chk("ovf.top", top4, 'h004);
    chk("ovf.d8_no_flag", ovf8, 0);
    cycle(0, 1, 10'h000, 0); chk("ovf.pop_top", top4, 'h003);
    cycle(0, 0, 10'h000, 1); chk("ovf.cleared", ovf4, 0);

    // Drain, then underflow
    repeat (5) cycle(0, 1, 10'h000, 0);
    cycle(0, 0, 10'h000, 1);
    cycle(0, 1, 10'h000, 0);
    chk("unf.flag", unf8, 1);
    chk("unf.count", cnt8, 0);
    cycle(0, 0, 10'h000, 1);

    // Simultaneous push+pop replaces the top
    cycle(1, 0, 10'h020, 0);
    cycle(1, 0, 10'h021, 0);
    cycle(1, 1, 10'h2AA, 0);
    chk("repl.count", cnt8, 2);
    chk("repl.top", top8, 'h2AA);
    cycle(0, 1, 10'h000, 0); chk("repl.pop_top", top8, 'h020);

    // Simultaneous push+pop on empty: push plus underflow
    cycle(0, 1, 10'h000, 0);
    cycle(0, 0, 10'h000, 1);
    cycle(1, 1, 10'h155, 0);
    chk("pp_empty.count", cnt8, 1);
    chk("pp_empty.top", top8, 'h155);
    chk("pp_empty.unf", unf8, 1);

    // Asynchronous reset between edges
    cycle(1, 0, 10'h0B1, 0);
    cycle(1, 0, 10'h0B2, 0);
    chk("arst.count_before", cnt8, 3);
    cycle(0, 0, 10'h000, 0);
    #2 RST_N = 1'b0;
    model_reset();
    #1;
    chk("arst.count", cnt8, 0);
    chk("arst.top", top8, 0);
    chk("arst.flags", {ovf8, unf8, ovf4, unf4}, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    cycle(1, 0, 10'h007, 0);
    chk("arst.push_top", top8, 'h007);
    chk("arst.push_count", cnt8, 1);

    // PC integration: RET loads the pre-edge top while the stack pops
    cycle(0, 1, 10'h000, 0);
    cycle(1, 0, 10'h05A, 0);
    cycle(1, 0, 10'h0A5, 0);
    pc_ld = 1'b1;
    cycle(0, 1, 10'h000, 0);
    pc_ld = 1'b0;
    chk("pc.loaded", pc, 'h0A5);
    chk("pc.new_top", top8, 'h05A);

    // Randomised phases alternating push-heavy, pop-heavy and balanced traffic
    for (int i = 0; i < 3000; i++) begin
      int phase, r, push_pct, pop_pct;
      phase = (i / 200) % 3;
      push_pct = (phase == 0) ? 70 : (phase == 1) ? 25 : 50;
      pop_pct  = (phase == 0) ? 25 : (phase == 1) ? 70 : 50;
      r = $urandom_range(0, 99);
      cycle(r < push_pct, $urandom_range(0, 99) < pop_pct,
            AW'($urandom_range(0, 1023)), $urandom_range(0, 99) < 6);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule

// File: doc/rat_ret_stack.md
Name: rat_ret_stack

Overview:
- Hardware return-address stack directly upstream of the RAT program counter; its FROM_STACK output feeds the PC mux's stack input.
- On CALL, the control unit pushes the return address (current PC_COUNT + 1); on RET, the PC loads FROM_STACK while the stack pops in the same cycle.
- Registered top-of-stack output, full/empty status, and sticky overflow/underflow error flags.

Parameters:
- ADDR_W, 10, width of a program address; matches PC_COUNT / FROM_STACK width.
- DEPTH, 8, number of return-address entries; must be >= 2.

Ports:
- CLK  in  1  system clock, rising-edge.
- RST_N  in  1  asynchronous active-low reset.
- PUSH  in  1  push PUSH_DATA this cycle (CALL).
- POP  in  1  pop top entry this cycle (RET).
- PUSH_DATA  in  ADDR_W  return address to push.
- CLR_ERR  in  1  synchronous clear of the OVERFLOW and UNDERFLOW flags.
- FROM_STACK  out  ADDR_W  current top of stack, registered; 0 when empty.
- COUNT  out  $clog2(DEPTH+1)  number of valid entries.
- FULL  out  1  COUNT == DEPTH (combinational from COUNT).
- EMPTY  out  1  COUNT == 0 (combinational from COUNT).
- OVERFLOW  out  1  sticky: a push was dropped because the stack was full.
- UNDERFLOW  out  1  sticky: a pop was attempted while the stack was empty.

Behaviour:
- Reset (RST_N low, async): COUNT=0, FROM_STACK=0, OVERFLOW=0, UNDERFLOW=0. EMPTY=1 and FULL=0 follow from COUNT. Entry array contents are don't-care.
- All state updates on the CLK rising edge when RST_N is high.
- FROM_STACK always equals entry[COUNT-1], or 0 if COUNT==0. It is held in a dedicated register and updated in the same edge as the push/pop, so it is valid one cycle after any change.
- PUSH only, not full: entry[COUNT] <= PUSH_DATA; COUNT+1; FROM_STACK <= PUSH_DATA.
- PUSH only, full: no change to entries, COUNT or FROM_STACK; OVERFLOW <= 1.
- POP only, COUNT>=2: COUNT-1; FROM_STACK <= entry[COUNT-2].
- POP only, COUNT==1: COUNT <= 0; FROM_STACK <= 0.
- POP only, empty: no state change; UNDERFLOW <= 1; FROM_STACK stays 0.
- PUSH and POP same cycle, COUNT>=1: replace top (entry[COUNT-1] <= PUSH_DATA, FROM_STACK <= PUSH_DATA); COUNT unchanged; no overflow even when full.
- PUSH and POP same cycle, empty: treated as PUSH only (COUNT <= 1, FROM_STACK <= PUSH_DATA), and UNDERFLOW <= 1.
- Read-before-pop contract: in a RET cycle the PC samples the pre-edge FROM_STACK while POP is asserted, giving zero-bubble returns.
- CLR_ERR clears both error flags at the edge. If an error event occurs in the same cycle, the set wins.
- Error flags never block later operations.
- No wrap-around: COUNT saturates at 0 and DEPTH.
- Reset asserted mid-sequence returns all outputs to reset values immediately, without waiting for CLK.
- X on PUSH or POP is a bench error. The design needs no X handling.

Test Plan:
- Reset/idle: RST_N=0 for 2 cycles, then 1 with PUSH=POP=0 -> FROM_STACK=0, COUNT=0, EMPTY=1, FULL=0, both flags 0.
- Push sequence: push 0x003, 0x010, 0x3FE on consecutive cycles -> after each edge FROM_STACK = 0x003/0x010/0x3FE and COUNT = 1/2/3. Then three pops -> FROM_STACK = 0x010/0x003/0x000, EMPTY=1 after the last.
- Overflow at DEPTH=4: push 0x001..0x004 -> FULL=1. Push 0x005 -> OVERFLOW=1, COUNT=4, FROM_STACK=0x004. Pop -> FROM_STACK=0x003. Pulse CLR_ERR -> OVERFLOW=0.
- Underflow and simultaneous ops: pop when empty -> UNDERFLOW=1, COUNT=0. With COUNT=2 (0x020, 0x021), PUSH=POP=1 with PUSH_DATA=0x2AA -> COUNT=2, FROM_STACK=0x2AA. Pop -> 0x020.
- Async reset mid-operation: with COUNT=3, drive RST_N low between clock edges -> COUNT=0 and FROM_STACK=0 before the next edge. Release and push 0x007 -> FROM_STACK=0x007, COUNT=1.
- PC integration: PC loads FROM_STACK (mux select 1) with PC_LD=1 and POP=1 on the same edge, with stack top 0x0A5 over 0x05A -> PC_COUNT=0x0A5 and FROM_STACK=0x05A after that edge.
